// File: rtl/chan_sum_scheduler_pkg.sv
// rtl/chan_sum_scheduler_pkg.sv - shared state type and width helpers for the channel-sum scheduler
package chan_sum_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    // Never below 1 bit so degenerate sizes still produce legal vectors
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pix_w(input int image_size);
        return width_of(image_size);
    endfunction

    function automatic int ch_w(input int channel_num_in);
        return width_of(channel_num_in);
    endfunction

    function automatic int map_w(input int channel_num);
        return width_of(channel_num);
    endfunction

    function automatic int sum_w(input int image_size);
        return width_of(image_size + 1);
    endfunction

endpackage

// File: rtl/chan_sum_scheduler_if.sv
// rtl/chan_sum_scheduler_if.sv - pixel stream, adder feed and adder result handshake bundle
interface chan_sum_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_W      = 10,
    parameter int CH_W       = 6
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  last_chan;
    logic [PIX_W-1:0]      pix_idx;
    logic [CH_W-1:0]       chan_idx;
    logic                  sum_valid;

    modport master (
        output s_valid, s_data, sum_valid,
        input  s_ready, m_valid, m_data, last_chan, pix_idx, chan_idx
    );

    modport slave (
        input  s_valid, s_data, sum_valid,
        output s_ready, m_valid, m_data, last_chan, pix_idx, chan_idx
    );
endinterface

// File: rtl/chan_sum_scheduler_wrap_counter.sv
// rtl/chan_sum_scheduler_wrap_counter.sv - modulo-MAX counter with clear and wrap strobe
module wrap_counter #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/chan_sum_scheduler.sv
// rtl/chan_sum_scheduler.sv - sequences channel-major partial sums into the adder tree and closes maps/frames
module chan_sum_scheduler
    import chan_sum_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNEL_NUM_IN = 64,
    parameter int IMAGE_SIZE     = 612,
    parameter int CHANNEL_NUM    = 12,
    localparam int PIX_W = pix_w(IMAGE_SIZE),
    localparam int CH_W  = ch_w(CHANNEL_NUM_IN),
    localparam int MAP_W = map_w(CHANNEL_NUM),
    localparam int SUM_W = sum_w(IMAGE_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    chan_sum_scheduler_if.slave   bus,
    output logic [MAP_W-1:0]      map_idx,
    output logic                  map_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err
);
    state_t state, state_nx;

    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W-1:0]  chan_cnt;
    logic [SUM_W-1:0] sum_cnt;
    logic accept, start_ok, pix_wrap, chan_wrap, map_wrap_unused;
    logic sum_full, map_close, last_map, last_ch, sum_legal, sum_ok, sum_bad;

    assign accept    = (state == LOAD) && bus.s_valid;
    assign start_ok  = (state == IDLE) && start;
    assign last_ch   = (chan_cnt == CH_W'(CHANNEL_NUM_IN - 1));
    assign sum_full  = (sum_cnt == SUM_W'(IMAGE_SIZE));
    assign map_close = (state == DRAIN) && sum_full;
    assign last_map  = (map_idx == MAP_W'(CHANNEL_NUM - 1));

    // Results may only arrive once the final channel has started feeding the tree
    assign sum_legal = ((state == LOAD) && last_ch) || (state == DRAIN);
    assign sum_ok    = bus.sum_valid && sum_legal && !sum_full;
    assign sum_bad   = bus.sum_valid && !sum_ok;

    wrap_counter #(.MAX(IMAGE_SIZE), .W(PIX_W)) u_pix (
        .clk(clk), .reset(reset), .clr(start_ok || map_close), .inc(accept),
        .cnt(pix_cnt), .wrap(pix_wrap)
    );

    wrap_counter #(.MAX(CHANNEL_NUM_IN), .W(CH_W)) u_chan (
        .clk(clk), .reset(reset), .clr(start_ok || map_close), .inc(pix_wrap),
        .cnt(chan_cnt), .wrap(chan_wrap)
    );

    // The last map is never incremented; DONE clears it instead
    wrap_counter #(.MAX(CHANNEL_NUM), .W(MAP_W)) u_map (
        .clk(clk), .reset(reset), .clr(start_ok || (state == DONE)),
        .inc(map_close && !last_map), .cnt(map_idx), .wrap(map_wrap_unused)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  if (chan_wrap) state_nx = DRAIN;
            DRAIN: if (map_close) state_nx = last_map ? DONE : LOAD;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready = (state == LOAD);
        busy        = (state != IDLE);
        map_done    = map_close;
        frame_done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (start_ok || map_close)
                sum_cnt <= '0;
            else if (sum_ok)
                sum_cnt <= sum_cnt + SUM_W'(1);
            if (sum_bad)
                err <= 1'b1;
            else if (start_ok)
                err <= 1'b0;
        end
    end

    // Index and last_chan tags travel with the word they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.m_valid   <= 1'b0;
            bus.m_data    <= '0;
            bus.pix_idx   <= '0;
            bus.chan_idx  <= '0;
            bus.last_chan <= 1'b0;
        end else begin
            bus.m_valid <= accept;
            if (accept) begin
                bus.m_data    <= bus.s_data;
                bus.pix_idx   <= pix_cnt;
                bus.chan_idx  <= chan_cnt;
                bus.last_chan <= last_ch;
            end
        end
    end
endmodule

// File: tb/tb_chan_sum_scheduler.sv
// tb/tb_chan_sum_scheduler.sv - directed self-checking bench for chan_sum_scheduler (4 ch, 5 px, 2 maps)
module tb_chan_sum_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic       inj;
    logic [0:0] map_idx;
    logic       map_done, frame_done, busy, err;

    int     n_cmp;
    int     n_bad;
    longint cyc;

    chan_sum_scheduler_if #(.DATA_WIDTH(32), .PIX_W(3), .CH_W(2)) bus ();

    chan_sum_scheduler #(
        .DATA_WIDTH(32), .CHANNEL_NUM_IN(4), .IMAGE_SIZE(5), .CHANNEL_NUM(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .map_idx(map_idx), .map_done(map_done), .frame_done(frame_done),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder tree: sum of the 4 channels of a pixel, result 8 cycles after the last-channel word
    logic [31:0] acc [0:7];
    logic [31:0] pd  [0:7];
    logic [7:0]  pv;

    always @(posedge clk) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv    <= {pv[6:0], bus.m_valid && bus.last_chan};
            pd[0] <= acc[bus.pix_idx] + bus.m_data;
            for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
            if (bus.m_valid)
                acc[bus.pix_idx] <= (bus.chan_idx == 2'd0) ? bus.m_data : acc[bus.pix_idx] + bus.m_data;
        end
    end

    assign bus.sum_valid = pv[7] | inj;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  p;
        logic [1:0]  c;
        logic        l;
        longint      t;
    } mword_t;

    mword_t      mlog [$];
    logic [31:0] sums [$];
    int          n_md, n_fd;
    longint      md_t, fd_t;

    always @(negedge clk) begin
        if (bus.m_valid) mlog.push_back('{bus.m_data, bus.pix_idx, bus.chan_idx, bus.last_chan, cyc});
        if (pv[7]) sums.push_back(pd[7]);
        if (map_done) begin
            n_md <= n_md + 1;
            md_t <= cyc;
        end
        if (frame_done) begin
            n_fd <= n_fd + 1;
            fd_t <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed_map(input bit toggle, input bit poke);
        int pix = 0;
        int ch  = 0;
        int n   = 0;
        bit v;
        bit rdy;
        while (ch < 4 && n < 200) begin
            v           = !toggle || (n % 2 == 0);
            bus.s_valid = v;
            bus.s_data  = 32'(ch * 10 + pix);
            start       = poke && (ch == 2) && (pix == 0);
            rdy         = bus.s_ready;
            tick();
            n++;
            if (v && rdy) begin
                pix++;
                if (pix == 5) begin
                    pix = 0;
                    ch++;
                end
            end
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        check("feed_bound", 64'(n < 200), 64'd1);
    endtask

    task automatic wait_map_done(input string tag);
        int i = 0;
        while (!map_done && i < 100) begin
            tick();
            i++;
        end
        check(tag, 64'(map_done), 64'd1);
    endtask

    task automatic check_log(input int base, input bit gaps);
        check($sformatf("mlog_size_%0d", base), 64'(mlog.size() >= base + 20), 64'd1);
        if (mlog.size() >= base + 20) begin
            for (int k = 0; k < 20; k++) begin
                mword_t e;
                e = mlog[base + k];
                check($sformatf("mword_%0d", base + k), 64'({e.d, e.p, e.c, e.l}),
                      64'({32'(k / 5 * 10 + k % 5), 3'(k % 5), 2'(k / 5), (k / 5 == 3)}));
                if (gaps && k > 0)
                    check($sformatf("mgap_%0d", base + k), 64'(e.t - mlog[base + k - 1].t), 64'd2);
            end
        end
    endtask

    task automatic check_sums(input int base);
        int exp_sum [5] = '{60, 64, 68, 72, 76};
        check($sformatf("sum_count_%0d", base), 64'(sums.size()), 64'(base + 5));
        if (sums.size() >= base + 5)
            for (int p = 0; p < 5; p++)
                check($sformatf("sum_%0d", base + p), 64'(sums[base + p]), 64'(exp_sum[p]));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_md  = 0;
        n_fd  = 0;
        md_t  = 0;
        fd_t  = 0;
        cyc   = 0;
        reset = 1'b1;
        start = 1'b0;
        inj   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_busy",     64'(busy),          64'd0);
        check("rst_s_ready",  64'(bus.s_ready),   64'd0);
        check("rst_m_valid",  64'(bus.m_valid),   64'd0);
        check("rst_err",      64'(err),           64'd0);
        check("rst_idx",      64'({map_idx, bus.pix_idx, bus.chan_idx, bus.last_chan}), 64'd0);
        check("rst_done",     64'({map_done, frame_done}), 64'd0);

        // sum_valid in IDLE is an error that sticks until the next start
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("idle_sum_err", 64'(err), 64'd1);
        tick();
        tick();
        tick();
        check("idle_err_held", 64'(err),  64'd1);
        check("idle_busy",     64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clr_err", 64'(err),         64'd0);
        check("start_load",    64'(bus.s_ready), 64'd1);

        // Map 0: gapless stream, stray start at chan 2 must be ignored
        feed_map(1'b0, 1'b1);
        check("s_ready_drop", 64'(bus.s_ready), 64'd0);
        check("drain_busy",   64'(busy),        64'd1);
        wait_map_done("map0_done");
        tick();
        check("map1_idx",  64'(map_idx),     64'd1);
        check("map1_load", 64'(bus.s_ready), 64'd1);
        check("map0_md",   64'(n_md),        64'd1);
        check_sums(0);
        check_log(0, 1'b0);

        // Map 1: s_valid toggling, words spaced by gaps
        feed_map(1'b1, 1'b0);
        wait_map_done("map1_done");
        check("legal_no_err", 64'(err), 64'd0);
        // Extra result while the map is already full
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("extra_sum_err", 64'(err),        64'd1);
        check("frame_done_hi", 64'(frame_done), 64'd1);
        check("done_no_md",    64'(map_done),   64'd0);
        tick();
        check("frame_idle",    64'(busy),       64'd0);
        check("frame_done_lo", 64'(frame_done), 64'd0);
        check("frame_map_clr", 64'(map_idx),    64'd0);
        check("md_count",      64'(n_md),       64'd2);
        check("fd_count",      64'(n_fd),       64'd1);
        check("fd_after_md",   64'(fd_t - md_t), 64'd1);
        check_sums(5);
        check_log(20, 1'b1);

        // Reset in DRAIN after three sums: abort with no map_done
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frame2_err_clr", 64'(err), 64'd0);
        feed_map(1'b0, 1'b0);
        begin
            int i = 0;
            while (sums.size() < 13 && i < 100) begin
                tick();
                i++;
            end
        end
        check("three_sums", 64'(sums.size()), 64'd13);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",    64'(busy),        64'd0);
        check("abort_s_ready", 64'(bus.s_ready), 64'd0);
        check("abort_idx",     64'({map_idx, bus.pix_idx, bus.chan_idx, bus.last_chan, bus.m_valid}), 64'd0);
        check("abort_err",     64'(err),         64'd0);
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_md",   64'(n_md), 64'd2);
        check("abort_no_fd",   64'(n_fd), 64'd1);
        check("abort_quiet",   64'({busy, err}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
